// File: rtl/issue_pkg.sv
// Shared constants for the in-order issue stage: unit codes, register-file
// defaults and the hard-wired zero register.
package issue_pkg;

  localparam int NREG_DEF = 64;
  localparam int RN_W_DEF = $clog2(NREG_DEF);
  localparam int REG_ZERO = 0;

  typedef enum logic [2:0] {
    UNIT_ALU1   = 3'd0,
    UNIT_ALU2   = 3'd1,
    UNIT_ADVINT = 3'd2,
    UNIT_MEM    = 3'd3,
    UNIT_BRANCH = 3'd4
  } unit_e;

endpackage

// File: rtl/issue_sched_busy_table.sv
// Register busy table: two set ports (issue), NFREE free ports (writeback),
// plus a same-cycle-free bypassed view used for hazard checks.
module busy_table
  import issue_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int RN_W  = $clog2(NREG),
  parameter int NFREE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RN_W-1:0]       set0_rn,
  input  logic                  set0_en,
  input  logic [RN_W-1:0]       set1_rn,
  input  logic                  set1_en,
  input  logic [NFREE*RN_W-1:0] free_rn,
  input  logic [NFREE-1:0]      free_en,
  output logic [NREG-1:0]       busy,
  output logic [NREG-1:0]       eff_busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] free_mask;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] busy_d;

  // Decode the ports into per-register masks; duplicate ports simply OR together.
  always_comb begin
    free_mask = '0;
    set_mask  = '0;
    for (int r = 0; r < NREG; r++) begin
      for (int k = 0; k < NFREE; k++) begin
        if (free_en[k] && free_rn[k*RN_W +: RN_W] == RN_W'(r))
          free_mask[r] = 1'b1;
      end
      if ((set0_en && set0_rn == RN_W'(r)) || (set1_en && set1_rn == RN_W'(r)))
        set_mask[r] = 1'b1;
    end
  end

  // A new owner supersedes an old writeback, so set wins over free.
  always_comb begin
    busy_d           = (busy_q & ~free_mask) | set_mask;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign busy     = busy_q;
  assign eff_busy = busy_q & ~free_mask;

endmodule

// File: rtl/issue_sched.sv
// In-order issue stage: RAW/WAW hazard check against the busy table, target
// unit availability, one-hot issue pulse, stall counter and bad-unit flag.
module issue_sched
  import issue_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int RN_W    = $clog2(NREG),
  parameter int NUNITS  = 5,
  parameter int UNIT_W  = 3,
  parameter int NFREE   = 2,
  parameter int STALL_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [UNIT_W-1:0]     in_unit,
  input  logic [RN_W-1:0]       in_rs1_rn,
  input  logic [RN_W-1:0]       in_rs2_rn,
  input  logic [RN_W-1:0]       in_rd_rn,
  input  logic [RN_W-1:0]       in_rd2_rn,
  input  logic                  in_rs1_en,
  input  logic                  in_rs2_en,
  input  logic                  in_rd_en,
  input  logic                  in_rd2_en,
  input  logic [NUNITS-1:0]     unit_busy,
  input  logic [NFREE*RN_W-1:0] free_rn,
  input  logic [NFREE-1:0]      free_en,
  output logic [NUNITS-1:0]     issue_en,
  output logic [RN_W-1:0]       issue_rd_rn,
  output logic [RN_W-1:0]       issue_rd2_rn,
  output logic [NREG-1:0]       reg_busy,
  output logic [STALL_W-1:0]    stall_cnt,
  output logic                  err_unit
);

  logic [NREG-1:0]   eff_busy;
  logic              hazard;
  logic              unit_ok;
  logic              unit_free;
  logic [NUNITS-1:0] unit_onehot;

  busy_table #(
    .NREG  (NREG),
    .RN_W  (RN_W),
    .NFREE (NFREE)
  ) u_busy_table (
    .clk      (clk),
    .rst      (rst),
    .set0_rn  (in_rd_rn),
    .set0_en  (in_ready & in_rd_en),
    .set1_rn  (in_rd2_rn),
    .set1_en  (in_ready & in_rd2_en),
    .free_rn  (free_rn),
    .free_en  (free_en),
    .busy     (reg_busy),
    .eff_busy (eff_busy)
  );

  function automatic logic operand_hazard(input logic en, input logic [RN_W-1:0] rn,
                                          input logic [NREG-1:0] eb);
    return en && (rn != RN_W'(REG_ZERO)) && eb[rn];
  endfunction

  // Unit lookup is done by loop so an out-of-range code never indexes unit_busy.
  always_comb begin
    unit_ok     = 1'b0;
    unit_free   = 1'b0;
    unit_onehot = '0;
    for (int u = 0; u < NUNITS; u++) begin
      if (in_unit == UNIT_W'(u)) begin
        unit_ok        = 1'b1;
        unit_free      = ~unit_busy[u];
        unit_onehot[u] = 1'b1;
      end
    end
    hazard = operand_hazard(in_rs1_en, in_rs1_rn, eff_busy) |
             operand_hazard(in_rs2_en, in_rs2_rn, eff_busy) |
             operand_hazard(in_rd_en,  in_rd_rn,  eff_busy) |
             operand_hazard(in_rd2_en, in_rd2_rn, eff_busy);
    in_ready = in_valid & ~hazard & unit_ok & unit_free;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_en     <= '0;
      issue_rd_rn  <= '0;
      issue_rd2_rn <= '0;
    end else if (in_ready) begin
      issue_en     <= unit_onehot;
      issue_rd_rn  <= in_rd_en  ? in_rd_rn  : '0;
      issue_rd2_rn <= in_rd2_en ? in_rd2_rn : '0;
    end else begin
      issue_en     <= '0;
    end
  end

  // Stall counter saturates rather than wrapping; err_unit is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      err_unit  <= 1'b0;
    end else begin
      if (in_valid && !in_ready && stall_cnt != {STALL_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
      if (in_valid && !unit_ok)
        err_unit <= 1'b1;
    end
  end

endmodule

// File: doc/issue_sched.md
Name: issue_sched

Overview:
- Parametrised in-order issue stage. It combines a multi-port register busy table with per-unit dispatch and a valid/ready front end.
- Sits between decode and the execution units. It issues at most one instruction per cycle to one of NUNITS units.
- Issues only when all source and destination registers are free (RAW/WAW protection) and the target unit is idle.
- Generalises the fixed two-port busy table and scheduler pair: configurable register count, unit count and free-port count, dual destinations, stall accounting and an error flag.

Parameters:
- NREG, 64, number of architectural registers; register 0 is hard-wired zero and never busy.
- RN_W, $clog2(NREG), register-number width.
- NUNITS, 5, number of execution units.
- UNIT_W, 3, unit-code width; must satisfy 2**UNIT_W >= NUNITS.
- NFREE, 2, number of writeback/free ports.
- STALL_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle (combinational)
- in_unit  in  UNIT_W  target unit code
- in_rs1_rn, in_rs2_rn, in_rd_rn, in_rd2_rn  in  RN_W each  register numbers
- in_rs1_en, in_rs2_en, in_rd_en, in_rd2_en  in  1 each  operand-used qualifiers
- unit_busy  in  NUNITS  per-unit busy from the execution units
- free_rn  in  NFREE*RN_W  packed writeback register numbers; port k is bits [k*RN_W +: RN_W]
- free_en  in  NFREE  per-port free strobe
- issue_en  out  NUNITS  registered one-hot issue pulse
- issue_rd_rn, issue_rd2_rn  out  RN_W each  registered destinations of the issued instruction
- reg_busy  out  NREG  busy vector; bit 0 is always 0
- stall_cnt  out  STALL_W  saturating count of stall cycles
- err_unit  out  1  sticky flag: in_valid was presented with in_unit >= NUNITS

Behaviour:
- Reset (async, rst=1): reg_busy=0, issue_en=0, issue_rd_rn=0, issue_rd2_rn=0, stall_cnt=0, err_unit=0. Reset asserted mid-operation discards all pending busy state immediately.
- Effective busy: eff_busy[r] = reg_busy[r] & ~(free_en[k] & free_rn[k]==r for any k). A same-cycle free bypasses the hazard check.
- hazard = OR of eff_busy over each enabled operand: rs1, rs2, rd, rd2. An operand naming register 0 never hazards.
- in_ready = in_valid & ~hazard & (in_unit < NUNITS) & ~unit_busy[in_unit].
- Issue (in_ready=1) at the clock edge:
  - issue_en is one-hot at in_unit for exactly one cycle.
  - issue_rd_rn/issue_rd2_rn are loaded with in_rd_rn/in_rd2_rn when the matching enable is set, otherwise 0.
  - reg_busy[rd] and reg_busy[rd2] are set.
  - Latency is one cycle from acceptance to issue_en and to the busy bits.
- No issue: issue_en=0 next cycle; issue_rd_rn/issue_rd2_rn hold their values.
- Busy-table update priority, per register per cycle: set-on-issue beats free, because a new owner supersedes an old writeback.
  - Free of a non-busy register: no effect.
  - Two free ports naming the same register: a single clear.
  - rd==rd2 on the same instruction: one bit set.
- Register 0: never set, and reg_busy[0] stays 0 permanently.
- Stall: stall_cnt increments when in_valid & ~in_ready and saturates at 2**STALL_W-1; it never wraps.
- err_unit: set when in_valid & in_unit >= NUNITS; cleared only by rst. Such an instruction is never accepted, so upstream sees permanent backpressure.
- No internal state machine beyond the busy table, output registers and counter. The block is fully pipelined at one instruction per cycle.

Decomposition:
- Shared package issue_pkg:
  - unit codes UNIT_ALU1=0, UNIT_ALU2=1, UNIT_ADVINT=2, UNIT_MEM=3, UNIT_BRANCH=4
  - default NREG and RN_W
  - zero-register constant REG_ZERO=0
- Sub-module busy_table: NREG/NFREE-parameterised storage with two set ports, the free ports, the bypassed eff_busy vector output, and the reg-0 rule.
- issue_sched instantiates busy_table and holds the hazard logic, ready logic, output registers and stall counter.

Test Plan:
- Reset release, then in_valid, unit=0, rs1=3, rs2=4, rd=5, all units idle -> in_ready=1 same cycle; next cycle issue_en=5'b00001, issue_rd_rn=5, reg_busy[5]=1.
- RAW: reg 5 busy, instruction with rs1=5 -> in_ready=0 and stall_cnt increments each cycle. Assert free_en[1] with free_rn[1]=5 -> in_ready=1 in that same cycle; reg_busy[5] stays 1 as re-set if the new rd=5, else becomes 0.
- Unit busy: unit_busy[3]=1 with a hazard-free unit=3 instruction -> in_ready=0. Drop unit_busy[3] -> accepted, and issue_en=5'b01000 next cycle.
- Dual destination with rd=7, rd2=7 and a register-0 operand (rs1=0, rd=0 on a second instruction) -> only reg_busy[7] set; reg_busy[0] stays 0; second instruction not blocked by reg 0.
- Stall saturation with STALL_W=4 and 20 stall cycles -> stall_cnt=15 and holds. in_unit=6 with in_valid -> err_unit=1 sticky, in_ready=0.
- Async reset asserted mid-stream with busy regs 5, 7, 9 -> reg_busy=0, issue_en=0 and stall_cnt=0 without waiting for a clock edge.
